// File: rtl/p2s_arbiter_if.sv
// Bus bundle between the display front ends, the P2S shifter and p2s_arbiter.
// The master side drives requests and the shifter EN. The slave side is the arbiter.
interface p2s_arbiter_if #(
   parameter int N_REQ     = 2,
   parameter int DATA_BITS = 32
);
   logic [N_REQ-1:0]           req;
   logic [N_REQ*DATA_BITS-1:0] req_data;
   logic [N_REQ-1:0]           ack;
   logic [N_REQ-1:0]           grant;
   logic                       busy;
   logic                       p2s_start;
   logic [DATA_BITS-1:0]       p2s_pdata;
   logic                       p2s_en;
   logic                       timeout_err;
   logic [1:0]                 err_id;

   modport master (
      output req, req_data, p2s_en,
      input  ack, grant, busy, p2s_start, p2s_pdata, timeout_err, err_id
   );

   modport slave (
      input  req, req_data, p2s_en,
      output ack, grant, busy, p2s_start, p2s_pdata, timeout_err, err_id
   );
endinterface

// File: rtl/p2s_arbiter.sv
// p2s_arbiter: round-robin sharing of one 32-bit parallel-to-serial shifter.
// The winner's word is latched onto the shifter's PData, and Start is pulsed.
// The arbiter then follows the shifter EN (1 = idle, 0 = shifting) to completion.
// Optional build macro P2S_ARB_SKIP_SAME_EN: a requester re-sending the word it
// last delivered successfully is acknowledged without a shifter transfer.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | no owner; waiting for a request while the shifter is idle
// S_LOAD      | grant and p2s_pdata valid; round-robin pointer moves to winner
// S_START     | p2s_start held high for START_HOLD cycles
// S_WAIT_BUSY | waiting up to BUSY_WAIT cycles for EN to fall
// S_WAIT_DONE | waiting up to DONE_TIMEOUT cycles for EN to rise
// S_DONE      | ack pulse to the owner; grant released afterwards
// S_ERR       | timeout: sticky error, err_id, ack pulse so the owner never hangs
// S_GAP       | GAP_CYCLES idle cycles before the next arbitration
module p2s_arbiter #(
   parameter int N_REQ        = 2,
   parameter int DATA_BITS    = 32,
   parameter int START_HOLD   = 4,
   parameter int BUSY_WAIT    = 8,
   parameter int DONE_TIMEOUT = 1023,
   parameter int GAP_CYCLES   = 2
) (
   input logic          i_clk,
   input logic          i_rst,
   p2s_arbiter_if.slave bus
);

   localparam int PW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int M1      = (START_HOLD > BUSY_WAIT) ? START_HOLD : BUSY_WAIT;
   localparam int M2      = (DONE_TIMEOUT > GAP_CYCLES) ? DONE_TIMEOUT : GAP_CYCLES;
   localparam int MAX_CNT = (M1 > M2) ? M1 : M2;
   localparam int CW      = $clog2(MAX_CNT + 1);

   // Down-counter reload values: the phase ends on the cycle the counter reads zero.
   localparam logic [CW-1:0] L_START = CW'((START_HOLD   > 0) ? START_HOLD   - 1 : 0);
   localparam logic [CW-1:0] L_BUSY  = CW'((BUSY_WAIT    > 0) ? BUSY_WAIT    - 1 : 0);
   localparam logic [CW-1:0] L_DONE  = CW'((DONE_TIMEOUT > 0) ? DONE_TIMEOUT - 1 : 0);
   localparam logic [CW-1:0] L_GAP   = CW'((GAP_CYCLES   > 0) ? GAP_CYCLES   - 1 : 0);
   localparam logic [N_REQ-1:0] L_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_DONE,
      S_ERR,
      S_GAP
   } state_t;

   state_t               r_state;
   logic [PW-1:0]        r_ptr;
   logic [PW-1:0]        r_win;
   logic [CW-1:0]        r_cnt;
   logic [N_REQ-1:0]     r_grant;
   logic [N_REQ-1:0]     r_ack;
   logic                 r_busy;
   logic                 r_start;
   logic [DATA_BITS-1:0] r_pdata;
   logic                 r_terr;
   logic [1:0]           r_err_id;

   logic                 w_found;
   logic [PW-1:0]        w_idx;
   logic [DATA_BITS-1:0] w_word;

   // Round-robin pick: the set request closest after r_ptr, wrapping around, wins.
   always_comb begin : p_rr
      int v_best;
      int v_dist;
      v_best  = N_REQ;
      v_dist  = 0;
      w_found = 1'b0;
      w_idx   = '0;
      w_word  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         v_dist = (i - int'(r_ptr) - 1 + N_REQ) % N_REQ;
         if (bus.req[i] && (v_dist < v_best)) begin
            v_best  = v_dist;
            w_found = 1'b1;
            w_idx   = PW'(i);
            w_word  = bus.req_data[i*DATA_BITS +: DATA_BITS];
         end
      end
   end

`ifdef P2S_ARB_SKIP_SAME_EN
   logic [DATA_BITS-1:0] r_last [N_REQ];
   logic [N_REQ-1:0]     r_last_vld;
   logic                 w_skip;

   assign w_skip = r_last_vld[r_win] && (r_last[r_win] == r_pdata);

   // Remember the last word each requester delivered; only real completions count.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_last_vld <= '0;
      end else if ((r_state == S_WAIT_DONE) && bus.p2s_en) begin
         r_last[r_win]     <= r_pdata;
         r_last_vld[r_win] <= 1'b1;
      end
   end
`endif

   // Arbitration and transfer sequencing; every output is a register of this FSM.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_ptr    <= PW'(N_REQ - 1);
         r_win    <= '0;
         r_cnt    <= '0;
         r_grant  <= '0;
         r_ack    <= '0;
         r_busy   <= 1'b0;
         r_start  <= 1'b0;
         r_pdata  <= '0;
         r_terr   <= 1'b0;
         r_err_id <= '0;
      end else begin
         r_ack <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_found && bus.p2s_en) begin
                  r_win   <= w_idx;
                  r_grant <= L_ONE << w_idx;
                  r_pdata <= w_word;
                  r_busy  <= 1'b1;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_ptr <= r_win;
`ifdef P2S_ARB_SKIP_SAME_EN
               if (w_skip) begin
                  r_ack   <= L_ONE << r_win;
                  r_state <= S_DONE;
               end else begin
                  r_start <= 1'b1;
                  r_cnt   <= L_START;
                  r_state <= S_START;
               end
`else
               r_start <= 1'b1;
               r_cnt   <= L_START;
               r_state <= S_START;
`endif
            end
            S_START: begin
               if (r_cnt == '0) begin
                  r_start <= 1'b0;
                  r_cnt   <= L_BUSY;
                  r_state <= S_WAIT_BUSY;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_WAIT_BUSY: begin
               if (!bus.p2s_en) begin
                  r_cnt   <= L_DONE;
                  r_state <= S_WAIT_DONE;
               end else if (r_cnt == '0) begin
                  r_terr   <= 1'b1;
                  r_err_id <= 2'(r_win);
                  r_ack    <= L_ONE << r_win;
                  r_state  <= S_ERR;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_WAIT_DONE: begin
               if (bus.p2s_en) begin
                  r_ack   <= L_ONE << r_win;
                  r_state <= S_DONE;
               end else if (r_cnt == '0) begin
                  r_terr   <= 1'b1;
                  r_err_id <= 2'(r_win);
                  r_ack    <= L_ONE << r_win;
                  r_state  <= S_ERR;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_DONE, S_ERR: begin
               r_grant <= '0;
               r_cnt   <= L_GAP;
               r_state <= S_GAP;
            end
            S_GAP: begin
               if (r_cnt == '0) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.ack         = r_ack;
   assign bus.grant       = r_grant;
   assign bus.busy        = r_busy;
   assign bus.p2s_start   = r_start;
   assign bus.p2s_pdata   = r_pdata;
   assign bus.timeout_err = r_terr;
   assign bus.err_id      = r_err_id;

endmodule

// File: tb/tb_p2s_arbiter.sv
// Directed bench for p2s_arbiter with a small cycle-counting shifter model.
// Shifter model: EN falls 2 cycles after Start is first seen high, rises 66 cycles later.
module tb_p2s_arbiter;
   localparam int N_REQ     = 2;
   localparam int DATA_BITS = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   p2s_arbiter_if #(.N_REQ(N_REQ), .DATA_BITS(DATA_BITS)) bus ();

   p2s_arbiter #(.N_REQ(N_REQ), .DATA_BITS(DATA_BITS)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Shifter model: 0 = normal, 1 = EN never falls, 2 = EN falls and sticks low.
   int   sh_mode     = 0;
   int   sh_cnt      = 0;
   logic sh_prev     = 1'b0;
   int   en_rise_cyc = -1;
   always @(negedge clk) begin
      if (rst) begin
         bus.p2s_en = 1'b1;
         sh_cnt     = 0;
         sh_prev    = 1'b0;
      end else begin
         if (bus.p2s_start && !sh_prev) sh_cnt = 1;
         else if (sh_cnt != 0)          sh_cnt = sh_cnt + 1;
         sh_prev = bus.p2s_start;
         if (sh_mode != 1 && sh_cnt == 3) bus.p2s_en = 1'b0;
         if (sh_mode == 0 && sh_cnt == 69) begin
            bus.p2s_en  = 1'b1;
            en_rise_cyc = cyc;
            sh_cnt      = 0;
         end
      end
   end

   // Monitor: Start edges and total cycles with any ack bit high.
   int   rise_q[$];
   int   fall_q[$];
   logic st_prev_m   = 1'b0;
   int   ack_cycles  = 0;
   always @(negedge clk) begin
      if (bus.p2s_start === 1'b1 && st_prev_m === 1'b0) rise_q.push_back(cyc);
      if (bus.p2s_start === 1'b0 && st_prev_m === 1'b1) fall_q.push_back(cyc);
      st_prev_m = bus.p2s_start;
      if (bus.ack !== '0 && !$isunknown(bus.ack)) ack_cycles++;
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_ack(input string tag, input int budget, output int acyc);
      int n;
      n = 0;
      while (bus.ack === '0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ack_seen"}, 32'(bus.ack !== '0), 32'd1);
      acyc = cyc;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
   end

   initial begin
      int         c0, ca, a0, r0;
      int         ack_c[4];
      logic [1:0] exp_a;

      bus.req      = '0;
      bus.req_data = '0;

      // Reset state
      rst = 1'b1;
      tick(3);
      chk("rst_ack",   bus.ack,         0);
      chk("rst_grant", bus.grant,       0);
      chk("rst_busy",  bus.busy,        0);
      chk("rst_start", bus.p2s_start,   0);
      chk("rst_pdata", bus.p2s_pdata,   0);
      chk("rst_terr",  bus.timeout_err, 0);
      chk("rst_errid", bus.err_id,      0);
      rst = 1'b0;
      tick(2);

      // Single request from requester 0
      sh_mode = 0;
      a0 = ack_cycles;
      r0 = rise_q.size();
      bus.req_data[31:0] = 32'h1234_5678;
      bus.req = 2'b01;
      c0 = cyc;
      wait_ack("single", 200, ca);
      chk("single_ack",       bus.ack,         2'b01);
      chk("single_grant",     bus.grant,       2'b01);
      chk("single_busy",      bus.busy,        1);
      chk("single_pdata",     bus.p2s_pdata,   32'h1234_5678);
      chk("single_terr",      bus.timeout_err, 0);
      chk("single_ack_lat",   ca - c0,         71);
      chk("single_en_to_ack", ca - en_rise_cyc, 1);
      bus.req = '0;
      tick(1);
      chk("single_ack_width", bus.ack,   0);
      chk("single_grant_rel", bus.grant, 0);
      tick(5);
      chk("single_ack_cycles",  ack_cycles - a0,    1);
      chk("single_start_count", rise_q.size() - r0, 1);
      if (rise_q.size() > r0 && fall_q.size() > r0) begin
         chk("single_start_rise", rise_q[r0] - c0,         2);
         chk("single_start_len",  fall_q[r0] - rise_q[r0], 4);
      end

      // Reset in WAIT_DONE: outputs clear, no ack, pointer back to requester 0 first
      a0 = ack_cycles;
      bus.req_data[31:0] = 32'hCAFE_F00D;
      bus.req = 2'b01;
      tick(20);
      chk("mid_en_low",  bus.p2s_en, 0);
      chk("mid_grant",   bus.grant,  2'b01);
      rst = 1'b1;
      tick(1);
      chk("mid_rst_ack",   bus.ack,         0);
      chk("mid_rst_grant", bus.grant,       0);
      chk("mid_rst_busy",  bus.busy,        0);
      chk("mid_rst_start", bus.p2s_start,   0);
      chk("mid_rst_pdata", bus.p2s_pdata,   0);
      chk("mid_rst_terr",  bus.timeout_err, 0);
      rst = 1'b0;
      chk("mid_rst_noack", ack_cycles - a0, 0);

      // Contention: both held, grants alternate 0,1,0,1 starting at 0
      a0 = ack_cycles;
      r0 = rise_q.size();
      bus.req_data[31:0]  = 32'h1111_0000;
      bus.req_data[63:32] = 32'h2222_0001;
      bus.req = 2'b11;
      exp_a = 2'b01;
      for (int k = 0; k < 4; k++) begin
         wait_ack($sformatf("rr%0d", k), 200, ca);
         ack_c[k] = ca;
         chk($sformatf("rr%0d_ack", k),   bus.ack,   exp_a);
         chk($sformatf("rr%0d_grant", k), bus.grant, exp_a);
         chk($sformatf("rr%0d_pdata", k), bus.p2s_pdata,
             (exp_a == 2'b01) ? 32'h1111_0000 : 32'h2222_0001);
         tick(1);
         chk($sformatf("rr%0d_ack_width", k), bus.ack, 0);
         exp_a = {exp_a[0], exp_a[1]};
      end
      bus.req = '0;
      tick(4);
      chk("rr_ack_cycles", ack_cycles - a0, 4);
      chk("rr_ack_period", ack_c[1] - ack_c[0], 74);
      if (rise_q.size() > r0 + 1) begin
         chk("rr_start_period", rise_q[r0+1] - rise_q[r0], 74);
         chk("rr_ack_to_start", rise_q[r0+1] - ack_c[0],   5);
      end else begin
         chk("rr_start_count", rise_q.size() - r0, 4);
      end

      // Busy timeout: EN never falls; requester 1 owns the transfer
      sh_mode = 1;
      bus.req_data[63:32] = 32'h0BAD_F00D;
      bus.req = 2'b10;
      c0 = cyc;
      wait_ack("btmo", 100, ca);
      chk("btmo_ack",   bus.ack,         2'b10);
      chk("btmo_lat",   ca - c0,         14);
      chk("btmo_terr",  bus.timeout_err, 1);
      chk("btmo_errid", bus.err_id,      1);
      bus.req = '0;
      tick(1);
      chk("btmo_ack_width", bus.ack,         0);
      chk("btmo_sticky",    bus.timeout_err, 1);
      sh_mode = 0;
      tick(4);

      // After the error the next request is still served
      bus.req_data[31:0] = 32'h600D_F00D;
      bus.req = 2'b01;
      c0 = cyc;
      wait_ack("after_err", 200, ca);
      chk("after_err_ack",    bus.ack,         2'b01);
      chk("after_err_pdata",  bus.p2s_pdata,   32'h600D_F00D);
      chk("after_err_lat",    ca - c0,         71);
      chk("after_err_sticky", bus.timeout_err, 1);
      bus.req = '0;
      tick(4);

      // Done timeout: EN stuck low
      sh_mode = 2;
      bus.req_data[31:0] = 32'h0000_D0DE;
      bus.req = 2'b01;
      c0 = cyc;
      wait_ack("dtmo", 1200, ca);
      chk("dtmo_ack",   bus.ack,         2'b01);
      chk("dtmo_lat",   ca - c0,         1030);
      chk("dtmo_terr",  bus.timeout_err, 1);
      chk("dtmo_errid", bus.err_id,      0);
      bus.req = '0;
      tick(1);
      chk("dtmo_ack_width", bus.ack, 0);
      rst = 1'b1;
      sh_mode = 0;
      tick(2);
      rst = 1'b0;
      chk("dtmo_rst_clears", bus.timeout_err, 0);
      tick(1);

      // Same word sent twice from requester 1, then a different word
      bus.req_data[63:32] = 32'hA5A5_A5A5;
      bus.req = 2'b10;
      c0 = cyc;
      wait_ack("same1", 200, ca);
      chk("same1_ack", bus.ack, 2'b10);
      chk("same1_lat", ca - c0, 71);
      bus.req = '0;
      tick(4);
      r0 = rise_q.size();
      bus.req = 2'b10;
      c0 = cyc;
      wait_ack("same2", 200, ca);
      chk("same2_ack", bus.ack, 2'b10);
      bus.req = '0;
      tick(4);
`ifdef P2S_ARB_SKIP_SAME_EN
      chk("same2_lat",    ca - c0,            2);
      chk("same2_starts", rise_q.size() - r0, 0);
`else
      chk("same2_lat",    ca - c0,            71);
      chk("same2_starts", rise_q.size() - r0, 1);
`endif
      r0 = rise_q.size();
      bus.req_data[63:32] = 32'hA5A5_A5A4;
      bus.req = 2'b10;
      c0 = cyc;
      wait_ack("diff", 200, ca);
      chk("diff_ack",   bus.ack,       2'b10);
      chk("diff_pdata", bus.p2s_pdata, 32'hA5A5_A5A4);
      chk("diff_lat",   ca - c0,       71);
      bus.req = '0;
      tick(4);
      chk("diff_starts", rise_q.size() - r0, 1);
      chk("final_terr",  bus.timeout_err,    0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
